// File: rtl/macro_harness_pkg.sv
// macro_harness_pkg
// Shared definitions for the macro test harness: command opcodes, the
// controller state encoding, and the CRC-8 polynomial with a byte-update
// helper. The CRC pieces are only used when MACRO_HARNESS_CRC_EN is defined.
package macro_harness_pkg;

  localparam logic [2:0] OP_SEL    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_APPLY  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RSP_B  = 2'd3
  } state_e;

  // One byte of CRC-8, processed MSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/macro_harness_crc8.sv
// macro_harness_crc8
// Byte-serial CRC-8 (poly 0x07, init 0x00). Instantiated by the harness only
// when MACRO_HARNESS_CRC_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the CRC at 0x00 (wins over upd)
//   upd        : fold data into the running CRC
//   data       : byte to fold in
//   crc        : running CRC value
module macro_harness_crc8
  import macro_harness_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       upd,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Next CRC value; clear takes priority over an update in the same cycle.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (upd) begin
      crc_d = crc8_update(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/macro_test_harness.sv
// macro_test_harness
// Byte-command harness that drives and observes up to N_CH macro channels.
// Commands arrive one byte at a time on cmd_*; READ/STATUS answers leave on
// rsp_*. Each channel has a drive register on mac_din, and there is one
// shadow register that LOAD fills. APPLY copies shadow into the selected
// channel, enables it for arg+1 cycles, then captures its mac_dout.
// Optional feature macro: MACRO_HARNESS_CRC_EN appends a CRC-8 byte to READ.
//   clk, rst_n           : clock, async active-low reset
//   cmd_valid/ready/data : command byte handshake
//   rsp_valid/ready/data : response byte handshake
//   mac_din              : per-channel stimulus, channel c at [c*DIN_W +: DIN_W]
//   mac_en               : one-hot enable of the channel under test
//   mac_dout             : per-channel observation
module macro_test_harness
  import macro_harness_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [N_CH*DIN_W-1:0]    mac_din,
  output logic [N_CH-1:0]          mac_en,
  input  logic [N_CH*DOUT_W-1:0]   mac_dout
);

  localparam int LOAD_BYTES = DIN_W / 8;
  localparam int RD_BYTES   = DOUT_W / 8;
`ifdef MACRO_HARNESS_CRC_EN
  localparam int RSP_BYTES  = RD_BYTES + 1;
`else
  localparam int RSP_BYTES  = RD_BYTES;
`endif
  localparam logic [2:0] LOAD_LAST = 3'(LOAD_BYTES - 1);
  localparam logic [2:0] RSP_LAST  = 3'(RSP_BYTES - 1);
  localparam logic [2:0] RD_NB     = 3'(RD_BYTES);
  localparam logic [4:0] N_CH_L    = 5'(N_CH);

  state_e                  state_q, state_d;
  logic [2:0]              sel_q, sel_d;
  logic                    err_q, err_d;
  logic [DIN_W-1:0]        shadow_q, shadow_d;
  logic [N_CH*DIN_W-1:0]   drive_q, drive_d;
  logic [DOUT_W-1:0]       capture_q, capture_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [4:0]              settle_q, settle_d;
  logic                    is_status_q, is_status_d;
  logic [7:0]              status_q, status_d;

  logic [2:0] op;
  logic [4:0] arg;
  logic       cmd_accept;
  logic       rsp_fire;

  assign op         = cmd_data[7:5];
  assign arg        = cmd_data[4:0];
  assign cmd_accept = cmd_valid & cmd_ready;
  assign rsp_fire   = rsp_valid & rsp_ready;

`ifdef MACRO_HARNESS_CRC_EN
  logic       crc_clr;
  logic       crc_upd;
  logic [7:0] crc_val;

  macro_harness_crc8 u_crc8 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .upd   (crc_upd),
    .data  (rsp_data),
    .crc   (crc_val)
  );
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 3'd0;
      err_q       <= 1'b0;
      shadow_q    <= '0;
      drive_q     <= '0;
      capture_q   <= '0;
      cnt_q       <= 3'd0;
      settle_q    <= 5'd0;
      is_status_q <= 1'b0;
      status_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      shadow_q    <= shadow_d;
      drive_q     <= drive_d;
      capture_q   <= capture_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      is_status_q <= is_status_d;
      status_q    <= status_d;
    end
  end

  // Next state and register updates. The STATUS byte is latched when the
  // command is accepted, so err can be cleared immediately.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    err_d       = err_q;
    shadow_d    = shadow_q;
    drive_d     = drive_q;
    capture_d   = capture_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    is_status_d = is_status_q;
    status_d    = status_q;
`ifdef MACRO_HARNESS_CRC_EN
    crc_clr     = 1'b0;
    crc_upd     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (op)
            OP_SEL: begin
              if (arg < N_CH_L) begin
                sel_d = arg[2:0];
              end else begin
                err_d = 1'b1;
              end
            end
            OP_LOAD: begin
              cnt_d   = 3'd0;
              state_d = ST_LOAD_B;
            end
            OP_APPLY: begin
              drive_d[sel_q*DIN_W +: DIN_W] = shadow_q;
              settle_d = arg;
              state_d  = ST_SETTLE;
            end
            OP_READ: begin
              cnt_d       = 3'd0;
              is_status_d = 1'b0;
              state_d     = ST_RSP_B;
`ifdef MACRO_HARNESS_CRC_EN
              crc_clr     = 1'b1;
`endif
            end
            OP_STATUS: begin
              status_d    = {err_q, 4'b0000, sel_q};
              err_d       = 1'b0;
              cnt_d       = 3'd0;
              is_status_d = 1'b1;
              state_d     = ST_RSP_B;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD_B: begin
        if (cmd_accept) begin
          shadow_d[cnt_q*8 +: 8] = cmd_data;
          if (cnt_q == LOAD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_SETTLE: begin
        // The counter holds the remaining settle cycles; capture on the
        // edge that closes the last one.
        if (settle_q == 5'd0) begin
          capture_d = mac_dout[sel_q*DOUT_W +: DOUT_W];
          state_d   = ST_IDLE;
        end else begin
          settle_d = settle_q - 5'd1;
        end
      end
      ST_RSP_B: begin
        if (rsp_fire) begin
`ifdef MACRO_HARNESS_CRC_EN
          crc_upd = !is_status_q && (cnt_q < RD_NB);
`endif
          if (is_status_q || cnt_q == RSP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD_B);
    rsp_valid = (state_q == ST_RSP_B);
    mac_en    = '0;
    rsp_data  = 8'h00;
    if (state_q == ST_SETTLE) begin
      mac_en = N_CH'(1) << sel_q;
    end
    if (state_q == ST_RSP_B) begin
      if (is_status_q) begin
        rsp_data = status_q;
      end else if (cnt_q < RD_NB) begin
        rsp_data = capture_q[cnt_q*8 +: 8];
      end else begin
`ifdef MACRO_HARNESS_CRC_EN
        rsp_data = crc_val;
`else
        rsp_data = 8'h00;
`endif
      end
    end
  end

  assign mac_din = drive_q;

endmodule
